// File: rtl/dc_launch_scheduler_if.sv
// dc_launch_scheduler_if: launch command, frame-load strobe and shared-engine handshake bundle.
interface dc_launch_scheduler_if;
   logic [3:0][31:0] i_launch_cmd;
   logic             i_launch_valid;
   logic             i_frame_valid;
   logic [4:0]       i_channel_sel;
   logic             i_engine_busy;
   logic             i_engine_done;
   logic             o_start;
   logic [4:0]       o_start_ch;
   modport master (
      output i_launch_cmd, i_launch_valid, i_frame_valid, i_channel_sel, i_engine_busy, i_engine_done,
      input  o_start, o_start_ch
   );
   modport slave (
      input  i_launch_cmd, i_launch_valid, i_frame_valid, i_channel_sel, i_engine_busy, i_engine_done,
      output o_start, o_start_ch
   );
endinterface

// File: rtl/dc_launch_scheduler.sv
// dc_launch_scheduler: issues engine starts in ascending channel order with gap, repeat, load gating and abort.
// Define DC_SCHED_TIMEOUT_EN to add the engine-done watchdog behind o_err_timeout.
module dc_launch_scheduler #(
   parameter int DAC_CHANNEL    = 24,
   parameter int GAP_W          = 16,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   dc_launch_scheduler_if.slave   bus,
   output logic [DAC_CHANNEL-1:0] o_loaded,
   output logic                   o_busy,
   output logic                   o_done,
   output logic                   o_cmd_drop,
   output logic                   o_err_timeout
);
   typedef enum logic [1:0] {IDLE, SELECT, WAIT_DONE, GAP} state_t;
   state_t                 state_q;
   logic [DAC_CHANNEL-1:0] mask_q, pend_q, mask_in, cand, low_oh, frame_oh, clr_oh;
   logic [15:0]            rep_q, pass_q, rep_in;
   logic [GAP_W-1:0]       gap_q, gcnt_q;
   logic [4:0]             low, ch_q;
   logic                   req_q, abort_q, start_q, done_q, drop_q, busy_q;
   logic                   launch, abort_cmd, done_in, tmo, got_done, last_pass, fire, unused_cmd;

   assign mask_in    = bus.i_launch_cmd[0][DAC_CHANNEL-1:0];
   assign rep_in     = bus.i_launch_cmd[1][15:0] == 16'd0 ? 16'd1 : bus.i_launch_cmd[1][15:0];
   assign launch     = bus.i_launch_valid && !bus.i_launch_cmd[3][0];
   assign abort_cmd  = bus.i_launch_valid && bus.i_launch_cmd[3][0];
   assign cand       = pend_q & (req_q ? o_loaded : '1);
   assign low_oh     = DAC_CHANNEL'(1) << low;
   assign last_pass  = {1'b0, pass_q} + 17'd1 >= {1'b0, rep_q};
   assign fire       = state_q == SELECT && !abort_q && !abort_cmd && |cand && !bus.i_engine_busy;
   // a done coinciding with our own start pulse belongs to an earlier job
   assign done_in    = bus.i_engine_done && !start_q;
   assign got_done   = state_q == WAIT_DONE && (done_in || tmo);
   assign frame_oh   = bus.i_frame_valid ? DAC_CHANNEL'(1) << bus.i_channel_sel : '0;
   assign clr_oh     = fire && last_pass ? low_oh : '0;
   assign unused_cmd = ^{bus.i_launch_cmd, TIMEOUT_CYCLES[0]};

   always_comb begin
      low = '0;
      for (int i = DAC_CHANNEL - 1; i >= 0; i--) low = cand[i] ? 5'(i) : low;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         mask_q   <= '0;
         pend_q   <= '0;
         rep_q    <= '0;
         pass_q   <= '0;
         gap_q    <= '0;
         gcnt_q   <= '0;
         ch_q     <= '0;
         req_q    <= 1'b0;
         abort_q  <= 1'b0;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         drop_q   <= 1'b0;
         busy_q   <= 1'b0;
         o_loaded <= '0;
      end else begin
         start_q  <= fire;
         done_q   <= 1'b0;
         drop_q   <= launch && state_q != IDLE;
         o_loaded <= (o_loaded & ~clr_oh) | frame_oh;
         if (fire) ch_q <= low;
         case (state_q)
            IDLE: if (launch) begin
               mask_q  <= mask_in;
               pend_q  <= mask_in;
               rep_q   <= rep_in;
               pass_q  <= '0;
               gap_q   <= bus.i_launch_cmd[2][GAP_W-1:0];
               req_q   <= bus.i_launch_cmd[3][1];
               state_q <= |mask_in ? SELECT : IDLE;
               busy_q  <= |mask_in;
               done_q  <= ~|mask_in;
            end
            SELECT: if (abort_q || abort_cmd) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               abort_q <= 1'b0;
               pend_q  <= '0;
            end else if (~|cand && !last_pass) begin
               pend_q <= mask_q;
               pass_q <= pass_q + 16'd1;
            end else if (~|cand) begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b1;
               pend_q  <= '0;
            end else begin
               pend_q  <= fire ? cand & ~low_oh : cand;
               state_q <= fire ? WAIT_DONE : SELECT;
            end
            WAIT_DONE: if (got_done) begin
               state_q <= gap_q != '0 ? GAP : SELECT;
               gcnt_q  <= gap_q - GAP_W'(1);
            end
            GAP: begin
               state_q <= gcnt_q == '0 ? SELECT : GAP;
               gcnt_q  <= gcnt_q - GAP_W'(1);
            end
            default: state_q <= IDLE;
         endcase
         if (abort_cmd && (state_q == WAIT_DONE || state_q == GAP)) begin
            abort_q <= 1'b1;
            pend_q  <= '0;
         end
      end
   end

`ifdef DC_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] tcnt_q;
   logic          err_q;
   assign tmo = state_q == WAIT_DONE && !done_in && tcnt_q == TW'(TIMEOUT_CYCLES - 1);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         tcnt_q <= '0;
         err_q  <= 1'b0;
      end else begin
         tcnt_q <= state_q == WAIT_DONE && !done_in && !tmo ? tcnt_q + TW'(1) : '0;
         err_q  <= state_q == IDLE && launch ? 1'b0 : err_q | tmo;
      end
   end
   assign o_err_timeout = err_q;
`else
   assign tmo           = 1'b0;
   assign o_err_timeout = 1'b0;
`endif

   assign bus.o_start    = start_q;
   assign bus.o_start_ch = ch_q;
   assign o_busy         = busy_q;
   assign o_done         = done_q;
   assign o_cmd_drop     = drop_q;
endmodule

// File: doc/dc_launch_scheduler.md
# dc_launch_scheduler

Sequences launch commands across the DAC channels. It consumes the 4-word launch command and the per-channel frame-valid events produced by the DC frame dispatcher. It issues one start at a time to the shared waveform/DAC update engine, in ascending channel order, with a programmable inter-start gap, a repeat count, optional gating on loaded frames, and abort handling.

## Interface
Parameters:
- DAC_CHANNEL, 24, number of schedulable channels (max 32)
- GAP_W, 16, width of inter-start gap counter
- TIMEOUT_CYCLES, 65535, max cycles to wait for engine done

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous, active-high reset
- i_launch_cmd  in  [3:0][31:0]  launch command words, sampled when i_launch_valid=1
- i_launch_valid  in  1  single-cycle command strobe
- i_frame_valid  in  1  single-cycle strobe: a DC frame was loaded for i_channel_sel
- i_channel_sel  in  5  channel of loaded frame
- i_engine_busy  in  1  shared engine cannot accept a start
- i_engine_done  in  1  single-cycle pulse: engine finished current start
- o_start  out  1  single-cycle start pulse to engine
- o_start_ch  out  5  channel for o_start, held until next start
- o_loaded  out  DAC_CHANNEL  per-channel frame-loaded flags
- o_busy  out  1  scheduler not in IDLE
- o_done  out  1  single-cycle pulse: command completed normally
- o_cmd_drop  out  1  single-cycle pulse: non-abort command received while busy
- o_err_timeout  out  1  sticky: engine done not seen within TIMEOUT_CYCLES

## Operation
- Command decode:
  - word0[DAC_CHANNEL-1:0] is the channel mask.
  - word1[15:0] is the repeat count; 0 is treated as 1.
  - word2[GAP_W-1:0] is the gap in cycles.
  - word3[0] is abort.
  - word3[1] is require_loaded.
- States: IDLE, SELECT, WAIT_DONE, GAP.
- IDLE:
  - A non-abort launch latches mask→pending, pass=0, clears o_err_timeout, then goes to SELECT.
  - A zero mask goes straight to o_done and stays in IDLE.
  - An abort in IDLE is ignored.
- SELECT:
  - candidates = pending & (require_loaded ? o_loaded : all-ones).
  - Non-candidate pending bits are cleared without a start.
  - If no candidate remains and pass+1 < repeat: reload pending=mask, pass++, remain in SELECT.
  - If no candidate remains otherwise: pulse o_done, go to IDLE.
  - Else wait while i_engine_busy=1. Then pulse o_start with o_start_ch = lowest candidate index, clear that bit, and go to WAIT_DONE.
- WAIT_DONE:
  - On i_engine_done: go to GAP if gap>0, else SELECT.
  - i_engine_done in the same cycle as o_start is ignored.
- GAP: count gap cycles, then go to SELECT.
- Loaded flags:
  - i_frame_valid with i_channel_sel < DAC_CHANNEL sets o_loaded[sel].
  - A start on the final pass clears o_loaded[ch].
  - A set and a clear on the same channel in the same cycle: set wins.
  - sel >= DAC_CHANNEL is ignored.
- Launch while busy:
  - With abort=1, pending is cleared and the current WAIT_DONE/GAP finishes, then the scheduler returns to IDLE. o_done is not pulsed.
  - With abort=0, the command is discarded and o_cmd_drop pulses.

## Timing
- Reset values: o_start=0, o_start_ch=0, o_loaded=0, o_busy=0, o_done=0, o_cmd_drop=0, o_err_timeout=0; state IDLE, counters 0.
- Reset mid-command aborts immediately; no further o_start is issued.
- Launch sampled at edge N: o_busy=1 from N+1, first o_start high in cycle N+2 (engine not busy).
- Gap semantics: done seen at edge D with gap=G>0 gives the next o_start in cycle D+G+2. With gap=0, it is in cycle D+2.
- Repeat reload in SELECT costs one cycle.
- o_done asserts one cycle after the SELECT that finds the final pass empty. o_busy drops in the same cycle.
- All outputs are registered.

## Configuration
- DC_SCHED_TIMEOUT_EN defined:
  - WAIT_DONE counts cycles.
  - After TIMEOUT_CYCLES cycles with no i_engine_done, o_err_timeout is set (sticky) and the scheduler proceeds as if done was received.
- Not defined:
  - WAIT_DONE waits indefinitely.
  - o_err_timeout is tied to 0 and no counter is instantiated.

## Test plan
- Mask 0x000005, repeat 1, gap 0, engine done 3 cycles after each start → starts on ch0 then ch2, then one o_done pulse.
- Mask 0x000003, repeat 2, gap 4 → start sequence ch0, ch1, ch0, ch1; start-to-start spacing after each done = 6 cycles; o_done once.
- Frames loaded on ch1 only; mask 0x000007 with require_loaded=1 → single start on ch1; o_loaded[1] cleared afterwards; ch0 and ch2 skipped.
- Second non-abort launch during WAIT_DONE → o_cmd_drop pulses; the original sequence is unaffected. An abort launch instead → the current start completes, no further starts, o_busy falls, and there is no o_done.
- Hold i_engine_busy=1 for 10 cycles in SELECT → o_start delayed until the cycle after busy falls. With DC_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=8, withholding done → o_err_timeout=1 and the next channel starts.
- i_frame_valid on ch3 in the same cycle as the final-pass start on ch3 → o_loaded[3] stays 1. i_rst asserted mid-GAP → all outputs 0 on the next cycle.
